apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_apb_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter: one transfer per grant, ties alternate, onto a single completer.
// Optional access-phase timeout is compiled in when APB_ARBITER_TIMEOUT_EN is defined.
module apb_arbiter #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    pclk,
    input  logic                    preset_n,

    input  logic                    s0_psel,
    input  logic                    s0_penable,
    input  logic [ADDR_WIDTH-1:0]   s0_paddr,
    input  logic                    s0_pwrite,
    input  logic [DATA_WIDTH-1:0]   s0_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s0_pstrb,
    output logic                    s0_pready,
    output logic [DATA_WIDTH-1:0]   s0_prdata,
    output logic                    s0_pslverr,

    input  logic                    s1_psel,
    input  logic                    s1_penable,
    input  logic [ADDR_WIDTH-1:0]   s1_paddr,
    input  logic                    s1_pwrite,
    input  logic [DATA_WIDTH-1:0]   s1_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s1_pstrb,
    output logic                    s1_pready,
    output logic [DATA_WIDTH-1:0]   s1_prdata,
    output logic                    s1_pslverr,

    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [ADDR_WIDTH-1:0]   m_paddr,
    output logic [DATA_WIDTH-1:0]   m_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_pstrb,
    input  logic                    m_pready,
    input  logic                    m_pslverr,
    input  logic [DATA_WIDTH-1:0]   m_prdata,

    output logic [1:0]              grant
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    owner, owner_nxt;
    logic                    last_grant, last_grant_nxt;
    logic                    dropped, dropped_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_nxt;
    logic                    pwrite_q, pwrite_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_nxt;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_nxt;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
    logic                    slverr_q, slverr_nxt;

    logic                    win;
    logic                    owner_psel;
    logic                    resp_vld;
    logic                    tmo_expired;

    // Requester penable carries no information the arbiter needs: psel alone marks a request.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    // Tie goes to whoever was not granted last; a lone request wins outright.
    assign win        = (s0_psel && s1_psel) ? ~last_grant : s1_psel;
    assign owner_psel = owner ? s1_psel : s0_psel;

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && state_nxt == ACCESS) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        dropped_nxt    = dropped;
        paddr_nxt      = paddr_q;
        pwrite_nxt     = pwrite_q;
        pwdata_nxt     = pwdata_q;
        pstrb_nxt      = pstrb_q;
        rdata_nxt      = rdata_q;
        slverr_nxt     = slverr_q;
        case (state)
            IDLE: begin
                if (s0_psel || s1_psel) begin
                    owner_nxt      = win;
                    last_grant_nxt = win;
                    dropped_nxt    = 1'b0;
                    paddr_nxt      = win ? s1_paddr  : s0_paddr;
                    pwrite_nxt     = win ? s1_pwrite : s0_pwrite;
                    pwdata_nxt     = win ? s1_pwdata : s0_pwdata;
                    pstrb_nxt      = win ? s1_pstrb  : s0_pstrb;
                    state_nxt      = SETUP;
                end
            end
            SETUP: begin
                dropped_nxt = dropped | ~owner_psel;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // A requester that walks away still lets the completer finish; only its response is suppressed.
                dropped_nxt = dropped | ~owner_psel;
                if (m_pready) begin
                    rdata_nxt  = m_prdata;
                    slverr_nxt = m_pslverr;
                    state_nxt  = RESP;
                end else if (tmo_expired) begin
                    rdata_nxt  = '0;
                    slverr_nxt = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            dropped    <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            dropped    <= dropped_nxt;
            paddr_q    <= paddr_nxt;
            pwrite_q   <= pwrite_nxt;
            pwdata_q   <= pwdata_nxt;
            pstrb_q    <= pstrb_nxt;
            rdata_q    <= rdata_nxt;
            slverr_q   <= slverr_nxt;
        end
    end

    assign m_psel    = (state == SETUP) || (state == ACCESS);
    assign m_penable = (state == ACCESS);
    assign m_paddr   = paddr_q;
    assign m_pwrite  = pwrite_q;
    assign m_pwdata  = pwdata_q;
    assign m_pstrb   = pstrb_q;
    assign grant     = m_psel ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // Response lines are gated so the non-owner and idle cycles always read as zero.
    assign resp_vld   = (state == RESP) && !dropped;
    assign s0_pready  = resp_vld && !owner;
    assign s1_pready  = resp_vld && owner;
    assign s0_prdata  = s0_pready ? rdata_q : '0;
    assign s1_prdata  = s1_pready ? rdata_q : '0;
    assign s0_pslverr = s0_pready && slverr_q;
    assign s1_pslverr = s1_pready && slverr_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter; timeout scenario follows APB_ARBITER_TIMEOUT_EN.
module tb_apb_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          s0_psel, s0_penable, s0_pwrite, s0_pready, s0_pslverr;
    logic [AW-1:0] s0_paddr;
    logic [DW-1:0] s0_pwdata, s0_prdata;
    logic [SW-1:0] s0_pstrb;
    logic          s1_psel, s1_penable, s1_pwrite, s1_pready, s1_pslverr;
    logic [AW-1:0] s1_paddr;
    logic [DW-1:0] s1_pwdata, s1_prdata;
    logic [SW-1:0] s1_pstrb;
    logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_prdata;
    logic [SW-1:0] m_pstrb;
    logic [1:0]    grant;

    int vectors = 0;
    int miscompares = 0;

    // Completer: ready once cmp_wait wait states have elapsed in the access phase.
    int            cmp_wait = 0;
    logic          cmp_hang = 1'b0;
    logic          cmp_err = 1'b0;
    logic [DW-1:0] cmp_rdata = '0;
    int            acc_cnt;

    always #5 pclk = ~pclk;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) acc_cnt <= 0;
        else           acc_cnt <= (m_penable && !m_pready) ? acc_cnt + 1 : 0;
    end

    assign m_pready  = m_penable && !cmp_hang && (acc_cnt >= cmp_wait);
    assign m_prdata  = m_pready ? cmp_rdata : '0;
    assign m_pslverr = m_pready && cmp_err;

    apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_paddr(s0_paddr), .s0_pwrite(s0_pwrite),
        .s0_pwdata(s0_pwdata), .s0_pstrb(s0_pstrb), .s0_pready(s0_pready), .s0_prdata(s0_prdata),
        .s0_pslverr(s0_pslverr),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_paddr(s1_paddr), .s1_pwrite(s1_pwrite),
        .s1_pwdata(s1_pwdata), .s1_pstrb(s1_pstrb), .s1_pready(s1_pready), .s1_prdata(s1_prdata),
        .s1_pslverr(s1_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
        .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .m_prdata(m_prdata), .grant(grant)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic idle_reqs();
        s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_paddr = '0; s0_pwdata = '0; s0_pstrb = '0;
        s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_paddr = '0; s1_pwdata = '0; s1_pstrb = '0;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        idle_reqs();
        cmp_wait = 0; cmp_hang = 0; cmp_err = 0; cmp_rdata = '0;
        step(2);
        vectors++;
        if ({m_psel, m_penable, m_pwrite, grant} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000", {m_psel, m_penable, m_pwrite, grant});
        end
        vectors++;
        if ({m_paddr, m_pwdata, m_pstrb} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got %h required 0", {m_paddr, m_pwdata, m_pstrb});
        end
        vectors++;
        if ({s0_pready, s0_pslverr, s0_prdata, s1_pready, s1_pslverr, s1_prdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_resp: got %h required 0",
                     {s0_pready, s0_pslverr, s0_prdata, s1_pready, s1_pslverr, s1_prdata});
        end
        preset_n = 1'b1;
        step(1);
        vectors++;
        if ({m_psel, grant} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b required 000", {m_psel, grant});
        end
    endtask

    task automatic test_read();
        s0_paddr = 24'h000400; s0_pwrite = 0; s0_psel = 1;
        cmp_wait = 0; cmp_rdata = 32'hDEADBEEF; cmp_err = 0;
        step(1);
        s0_penable = 1;
        vectors++;
        if ({m_psel, m_penable, grant} !== 4'b1001) begin
            miscompares++;
            $display("FAIL read_c1_ctrl: got %b required 1001", {m_psel, m_penable, grant});
        end
        vectors++;
        if ({m_pwrite, m_paddr} !== {1'b0, 24'h000400}) begin
            miscompares++;
            $display("FAIL read_c1_addr: got %h required 000400", {m_pwrite, m_paddr});
        end
        step(1);
        vectors++;
        if ({m_psel, m_penable, grant, s0_pready} !== 5'b11010) begin
            miscompares++;
            $display("FAIL read_c2_ctrl: got %b required 11010", {m_psel, m_penable, grant, s0_pready});
        end
        step(1);
        vectors++;
        if ({s0_pready, s0_pslverr, s0_prdata} !== {2'b10, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL read_c3_resp: got %h required 2deadbeef", {s0_pready, s0_pslverr, s0_prdata});
        end
        vectors++;
        if ({m_psel, m_penable, grant, s1_pready, s1_pslverr, s1_prdata} !== '0) begin
            miscompares++;
            $display("FAIL read_c3_quiet: got %h required 0",
                     {m_psel, m_penable, grant, s1_pready, s1_pslverr, s1_prdata});
        end
        s0_psel = 0; s0_penable = 0;
        step(1);
        vectors++;
        if ({s0_pready, s0_prdata} !== '0) begin
            miscompares++;
            $display("FAIL read_c4_single_pulse: got %h required 0", {s0_pready, s0_prdata});
        end
    endtask

    task automatic test_arbitration();
        logic [1:0]    eg [0:11];
        logic [11:0]   e_s0, e_s1;
        logic [AW-1:0] ea;
        preset_n = 1'b0;
        step(1);
        preset_n = 1'b1;
        step(1);
        eg   = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        e_s0 = 12'b1000_0000_1000;
        e_s1 = 12'b0000_1000_0000;
        cmp_wait = 0; cmp_rdata = 32'h11110000; cmp_err = 0;
        s0_paddr = 24'h000010; s1_paddr = 24'h000020;
        s0_psel = 1; s1_psel = 1;
        for (int c = 1; c <= 11; c++) begin
            step(1);
            vectors++;
            if (grant !== eg[c]) begin
                miscompares++;
                $display("FAIL arb_grant c%0d: got %b required %b", c, grant, eg[c]);
            end
            vectors++;
            if ({s0_pready, s1_pready} !== {e_s0[c], e_s1[c]}) begin
                miscompares++;
                $display("FAIL arb_pready c%0d: got %b required %b", c, {s0_pready, s1_pready},
                         {e_s0[c], e_s1[c]});
            end
            if (eg[c] != 2'b00) begin
                ea = (eg[c] == 2'b10) ? 24'h000020 : ((c < 5) ? 24'h000010 : 24'h000030);
                vectors++;
                if (m_paddr !== ea) begin
                    miscompares++;
                    $display("FAIL arb_addr c%0d: got %h required %h", c, m_paddr, ea);
                end
            end
            if (c == 3)  s0_paddr = 24'h000030;
            if (c == 7)  s1_psel = 0;
            if (c == 11) s0_psel = 0;
        end
        step(1);
    endtask

    task automatic test_write_wait();
        s1_paddr = 24'h00ABCD; s1_pwrite = 1; s1_pwdata = 32'h00AAAA55; s1_pstrb = 4'hF; s1_psel = 1;
        cmp_wait = 3; cmp_rdata = '0; cmp_err = 0;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (c == 2) s1_pwdata = 32'hFFFFFFFF;
            vectors++;
            if ({s0_pready, s0_pslverr, s0_prdata} !== '0) begin
                miscompares++;
                $display("FAIL wr_s0_quiet c%0d: got %h required 0", c, {s0_pready, s0_pslverr, s0_prdata});
            end
            if (c <= 5) begin
                vectors++;
                if ({m_psel, m_penable, grant, s1_pready} !== {1'b1, (c >= 2), 2'b10, 1'b0}) begin
                    miscompares++;
                    $display("FAIL wr_ctrl c%0d: got %b required %b", c, {m_psel, m_penable, grant, s1_pready},
                             {1'b1, (c >= 2), 2'b10, 1'b0});
                end
                vectors++;
                if ({m_pwrite, m_pstrb, m_paddr, m_pwdata} !== {1'b1, 4'hF, 24'h00ABCD, 32'h00AAAA55}) begin
                    miscompares++;
                    $display("FAIL wr_payload c%0d: got %h required 1f00abcd00aaaa55", c,
                             {m_pwrite, m_pstrb, m_paddr, m_pwdata});
                end
            end else begin
                vectors++;
                if ({s1_pready, s1_pslverr, m_psel, grant} !== 5'b10000) begin
                    miscompares++;
                    $display("FAIL wr_resp c6: got %b required 10000", {s1_pready, s1_pslverr, m_psel, grant});
                end
            end
        end
        s1_psel = 0; s1_pwrite = 0;
        step(1);
    endtask

    task automatic test_slverr();
        s0_paddr = 24'h000800; s0_pwrite = 0; s0_psel = 1;
        cmp_wait = 1; cmp_rdata = 32'hBAD0BAD0; cmp_err = 1;
        step(3);
        vectors++;
        if (s0_pready !== 1'b0) begin
            miscompares++;
            $display("FAIL err_early: got %b required 0", s0_pready);
        end
        step(1);
        vectors++;
        if ({s0_pready, s0_pslverr, s0_prdata} !== {2'b11, 32'hBAD0BAD0}) begin
            miscompares++;
            $display("FAIL err_resp: got %h required 3bad0bad0", {s0_pready, s0_pslverr, s0_prdata});
        end
        vectors++;
        if ({s1_pready, s1_pslverr, s1_prdata} !== '0) begin
            miscompares++;
            $display("FAIL err_s1_quiet: got %h required 0", {s1_pready, s1_pslverr, s1_prdata});
        end
        s0_psel = 0; cmp_err = 0;
        step(1);
    endtask

    task automatic test_drop();
        s1_paddr = 24'h000044; s1_pwrite = 0; s1_psel = 1;
        cmp_wait = 0; cmp_rdata = 32'hCAFEF00D;
        step(1);
        s1_psel = 0;
        step(1);
        vectors++;
        if ({m_psel, m_penable, grant} !== 4'b1110) begin
            miscompares++;
            $display("FAIL drop_access: got %b required 1110", {m_psel, m_penable, grant});
        end
        step(1);
        vectors++;
        if ({s1_pready, s1_pslverr, s1_prdata, m_psel, grant} !== '0) begin
            miscompares++;
            $display("FAIL drop_no_resp: got %h required 0", {s1_pready, s1_pslverr, s1_prdata, m_psel, grant});
        end
        s0_paddr = 24'h000050; s0_pwrite = 0; s0_psel = 1;
        step(2);
        vectors++;
        if ({grant, s1_pready} !== 3'b010) begin
            miscompares++;
            $display("FAIL drop_resp_one_cycle: got %b required 010", {grant, s1_pready});
        end
        step(2);
        vectors++;
        if ({s0_pready, s0_prdata} !== {1'b1, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL drop_next_resp: got %h required 1cafef00d", {s0_pready, s0_prdata});
        end
        s0_psel = 0;
        step(1);
    endtask

    task automatic test_reset_mid();
        s1_paddr = 24'h000060; s1_pwrite = 1; s1_pwdata = 32'h55AA55AA; s1_pstrb = 4'h3; s1_psel = 1;
        cmp_wait = 5;
        step(3);
        preset_n = 1'b0;
        #1;
        vectors++;
        if ({m_psel, m_penable, m_pwrite, grant, m_paddr, m_pwdata, m_pstrb} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_master: got %h required 0",
                     {m_psel, m_penable, m_pwrite, grant, m_paddr, m_pwdata, m_pstrb});
        end
        vectors++;
        if ({s0_pready, s0_pslverr, s0_prdata, s1_pready, s1_pslverr, s1_prdata} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_resp: got %h required 0",
                     {s0_pready, s0_pslverr, s0_prdata, s1_pready, s1_pslverr, s1_prdata});
        end
        s1_psel = 0; s1_pwrite = 0;
        step(2);
        preset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1);
            vectors++;
            if ({s0_pready, s1_pready, m_psel} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_stale c%0d: got %b required 000", c, {s0_pready, s1_pready, m_psel});
            end
        end
        cmp_wait = 0;
    endtask

    task automatic test_timeout();
        s0_paddr = 24'h000070; s0_pwrite = 0; s0_psel = 1;
        cmp_hang = 1; cmp_wait = 0; cmp_rdata = 32'h12345678;
`ifdef APB_ARBITER_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            step(1);
            if (c >= 2 && c <= 9) begin
                vectors++;
                if ({m_psel, m_penable, s0_pready} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL tmo_access c%0d: got %b required 110", c, {m_psel, m_penable, s0_pready});
                end
            end else if (c == 10) begin
                vectors++;
                if ({m_psel, m_penable, grant} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL tmo_drop: got %b required 0000", {m_psel, m_penable, grant});
                end
                vectors++;
                if ({s0_pready, s0_pslverr, s0_prdata} !== {2'b11, 32'h0}) begin
                    miscompares++;
                    $display("FAIL tmo_resp: got %h required 300000000", {s0_pready, s0_pslverr, s0_prdata});
                end
            end
        end
        s0_psel = 0; cmp_hang = 0;
        step(1);
`else
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (c >= 2) begin
                vectors++;
                if ({m_psel, m_penable, s0_pready} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL hold_access c%0d: got %b required 110", c, {m_psel, m_penable, s0_pready});
                end
            end
        end
        cmp_hang = 0;
        step(1);
        vectors++;
        if ({s0_pready, s0_pslverr, s0_prdata} !== {2'b10, 32'h12345678}) begin
            miscompares++;
            $display("FAIL hold_release: got %h required 212345678", {s0_pready, s0_pslverr, s0_prdata});
        end
        s0_psel = 0;
        step(1);
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_write_wait();
        test_slverr();
        test_drop();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
